// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: two 2-entry request buffers (ALU, load) share one registered write port.
// Optional macro RF_WB_FIXED_PRI_EN: the load buffer always wins a contest (no round-robin pointer).
module rf_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [AW-1:0]      alu_reg,
  input  logic [DW-1:0]      alu_data,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic [AW-1:0]      mem_reg,
  input  logic [DW-1:0]      mem_data,
  output logic               rf_we,
  output logic [AW-1:0]      write_reg,
  output logic [DW-1:0]      write_data,
  output logic               grant_mem,
  output logic [(1<<AW)-1:0] busy_mask
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  // Per-source buffer state; index 0 = ALU, 1 = load.
  logic [AW-1:0] r_reg  [2][2];
  logic [DW-1:0] r_data [2][2];
  logic [1:0]    r_cnt  [2];
  logic [1:0]    r_rd;
  logic [1:0]    r_wr;

  logic [1:0]    w_in_valid;
  logic [AW-1:0] w_in_reg  [2];
  logic [DW-1:0] w_in_data [2];
  logic [1:0]    w_ready;
  logic [1:0]    w_push;
  logic [1:0]    w_pop;
  logic [1:0]    w_ne;
  logic          w_any;
  src_e          w_sel;
  logic          w_sel_idx;
  logic [AW-1:0] w_head_reg;
  logic [DW-1:0] w_head_data;
  logic [(1<<AW)-1:0] w_busy;

`ifndef RF_WB_FIXED_PRI_EN
  src_e r_last;
`endif

  assign w_in_valid   = {mem_valid, alu_valid};
  assign w_in_reg[0]  = alu_reg;
  assign w_in_reg[1]  = mem_reg;
  assign w_in_data[0] = alu_data;
  assign w_in_data[1] = mem_data;

  always_comb begin
    for (int unsigned s = 0; s < 2; s++) begin
      w_ready[s] = (r_cnt[s] != 2'd2);
      w_ne[s]    = (r_cnt[s] != 2'd0);
      w_push[s]  = w_in_valid[s] && w_ready[s];
    end
  end

  assign alu_ready = w_ready[0];
  assign mem_ready = w_ready[1];

  always_comb begin
    w_sel = SRC_ALU;
`ifdef RF_WB_FIXED_PRI_EN
    if (w_ne[1]) w_sel = SRC_MEM;
`else
    if (w_ne[0] && w_ne[1])
      w_sel = (r_last == SRC_MEM) ? SRC_ALU : SRC_MEM;
    else if (w_ne[1])
      w_sel = SRC_MEM;
`endif
  end

  assign w_any       = |w_ne;
  assign w_sel_idx   = (w_sel == SRC_MEM);
  assign w_pop       = {w_any && w_sel_idx, w_any && !w_sel_idx};
  assign w_head_reg  = r_reg[w_sel_idx][r_rd[w_sel_idx]];
  assign w_head_data = r_data[w_sel_idx][r_rd[w_sel_idx]];

  // Payload storage carries no reset; validity comes solely from r_cnt.
  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < 2; s++) begin
      if (w_push[s]) begin
        r_reg[s][r_wr[s]]  <= w_in_reg[s];
        r_data[s][r_wr[s]] <= w_in_data[s];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
      r_rd     <= '0;
      r_wr     <= '0;
    end else begin
      for (int unsigned s = 0; s < 2; s++) begin
        if (w_push[s]) r_wr[s] <= ~r_wr[s];
        if (w_pop[s])  r_rd[s] <= ~r_rd[s];
        case ({w_push[s], w_pop[s]})
          2'b10:   r_cnt[s] <= r_cnt[s] + 2'd1;
          2'b01:   r_cnt[s] <= r_cnt[s] - 2'd1;
          default: r_cnt[s] <= r_cnt[s];
        endcase
      end
    end
  end

`ifndef RF_WB_FIXED_PRI_EN
  // Reset to "load won last" so the ALU takes the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_last <= SRC_MEM;
    else if (w_ne[0] && w_ne[1])
      r_last <= w_sel;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      grant_mem  <= 1'b0;
    end else if (w_any) begin
      rf_we      <= (w_head_reg != '0);
      write_reg  <= w_head_reg;
      write_data <= w_head_data;
      grant_mem  <= w_sel_idx;
    end else begin
      rf_we      <= 1'b0;
    end
  end

  always_comb begin
    w_busy = '0;
    for (int unsigned s = 0; s < 2; s++) begin
      for (int unsigned k = 0; k < 2; k++) begin
        if ((k == 0) ? (r_cnt[s] != 2'd0) : (r_cnt[s] == 2'd2))
          w_busy[r_reg[s][r_rd[s] ^ 1'(k)]] = 1'b1;
      end
    end
    if (rf_we) w_busy[write_reg] = 1'b1;
    w_busy[0] = 1'b0;
  end

  assign busy_mask = w_busy;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (follows RF_WB_FIXED_PRI_EN for ordering expectations).
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [3:0]  alu_reg = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [3:0]  mem_reg = '0;
  logic [31:0] mem_data = '0;
  logic        rf_we;
  logic [3:0]  write_reg;
  logic [31:0] write_data;
  logic        grant_mem;
  logic [15:0] busy_mask;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [3:0]  q_reg[$];
  logic        q_gm[$];
  logic [31:0] q_data[$];
  int          q_cyc[$];

  rf_wb_arbiter #(.DW(32), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .rf_we(rf_we), .write_reg(write_reg), .write_data(write_data),
    .grant_mem(grant_mem), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rf_we === 1'b1) begin
      q_reg.push_back(write_reg);
      q_gm.push_back(grant_mem);
      q_data.push_back(write_data);
      q_cyc.push_back(cyc);
    end
  end

  task automatic clear_mon();
    q_reg.delete(); q_gm.delete(); q_data.delete(); q_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; alu_valid = 1'b1; mem_valid = 1'b1;
    alu_reg = 4'd3; mem_reg = 4'd4;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %b exp 0", rf_we); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready got %b exp 1", alu_ready); end
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready got %b exp 1", mem_ready); end
    checks++; if (busy_mask !== 16'h0) begin errors++; $display("FAIL reset_busy got %h exp 0000", busy_mask); end
    checks++; if (write_reg !== 4'd0 || write_data !== 32'd0 || grant_mem !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got reg=%0d data=%h gm=%b exp 0/0/0", write_reg, write_data, grant_mem);
    end
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy_mask !== 16'h0 || rf_we !== 1'b0) begin
      errors++; $display("FAIL reset_no_push got busy=%h we=%b exp 0000/0", busy_mask, rf_we);
    end
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b%b exp 11", alu_ready, mem_ready);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    alu_valid = 1'b1; alu_reg = 4'd5; alu_data = 32'hDEADBEEF;
    @(negedge clk);  // edge N accepted
    alu_valid = 1'b0;
    checks++; if (busy_mask !== 16'h0020) begin errors++; $display("FAIL single_busy_N got %h exp 0020", busy_mask); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_we_N got %b exp 0", rf_we); end
    @(negedge clk);  // cycle N+1
    checks++; if (rf_we !== 1'b1 || write_reg !== 4'd5) begin
      errors++; $display("FAIL single_write got we=%b reg=%0d exp 1/5", rf_we, write_reg);
    end
    checks++; if (write_data !== 32'hDEADBEEF || grant_mem !== 1'b0) begin
      errors++; $display("FAIL single_data got %h gm=%b exp deadbeef/0", write_data, grant_mem);
    end
    checks++; if (busy_mask !== 16'h0020) begin errors++; $display("FAIL single_busy_N1 got %h exp 0020", busy_mask); end
    @(negedge clk);  // after N+2
    checks++; if (rf_we !== 1'b0 || busy_mask !== 16'h0) begin
      errors++; $display("FAIL single_done got we=%b busy=%h exp 0/0000", rf_we, busy_mask);
    end
    checks++; if (write_reg !== 4'd5 || write_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_hold got reg=%0d data=%h exp 5/deadbeef", write_reg, write_data);
    end
  endtask

  task automatic push_pairs();
    alu_valid = 1'b1; alu_reg = 4'd1; alu_data = 32'd11;
    mem_valid = 1'b1; mem_reg = 4'd3; mem_data = 32'd33;
    @(negedge clk);
    alu_reg = 4'd2; alu_data = 32'd22;
    mem_reg = 4'd4; mem_data = 32'd44;
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0;
  endtask

  task automatic test_contention();
    logic [3:0] exp_reg [4];
    logic       exp_gm  [4];
`ifdef RF_WB_FIXED_PRI_EN
    exp_reg = '{4'd3, 4'd4, 4'd1, 4'd2};
    exp_gm  = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
    exp_reg = '{4'd1, 4'd3, 4'd2, 4'd4};
    exp_gm  = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    do_reset();
    clear_mon();
    push_pairs();
    repeat (6) @(negedge clk);
    checks++; if (q_reg.size() != 4) begin errors++; $display("FAIL contention_count got %0d exp 4", q_reg.size()); end
    for (int i = 0; i < 4 && i < q_reg.size(); i++) begin
      checks++;
      if (q_reg[i] !== exp_reg[i] || q_gm[i] !== exp_gm[i] || q_data[i] !== 32'(exp_reg[i]) * 32'd11) begin
        errors++;
        $display("FAIL contention_order[%0d] got reg=%0d gm=%b data=%0d exp reg=%0d gm=%b data=%0d",
                 i, q_reg[i], q_gm[i], q_data[i], exp_reg[i], exp_gm[i], 32'(exp_reg[i]) * 32'd11);
      end
    end
    if (q_cyc.size() == 4) begin
      checks++;
      if (q_cyc[3] - q_cyc[0] != 3) begin
        errors++; $display("FAIL contention_b2b got span %0d cycles exp 3", q_cyc[3] - q_cyc[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int     accepted = 0;
    int     tries = 0;
    int     cycles = 0;
    logic   saw_full = 1'b0;
    logic   rdy;
    int     n_alu = 0;
    do_reset();
    clear_mon();
    mem_valid = 1'b1; mem_reg = 4'd7; mem_data = 32'h7000;
    alu_valid = 1'b1; alu_reg = 4'd8; alu_data = 32'hA000;
    while (accepted < 4 && tries < 30) begin
      rdy = alu_ready;
      if (!rdy) saw_full = 1'b1;
      @(negedge clk);
      tries++; cycles++;
      mem_data = mem_data + 32'd1;
      if (cycles >= 6) mem_valid = 1'b0;
      if (rdy) begin
        accepted++;
        alu_reg  = 4'(8 + accepted);
        alu_data = 32'hA000 + 32'(accepted);
      end
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    checks++; if (accepted != 4) begin errors++; $display("FAIL bp_accept got %0d exp 4 within budget", accepted); end
    repeat (10) @(negedge clk);
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL bp_ready_drop got %b exp 1", saw_full); end
    for (int i = 0; i < q_reg.size(); i++) begin
      if (q_gm[i] == 1'b0) begin
        checks++;
        if (n_alu >= 4 || q_data[i] !== 32'hA000 + 32'(n_alu) || q_reg[i] !== 4'(8 + n_alu)) begin
          errors++; $display("FAIL bp_alu_order[%0d] got reg=%0d data=%h exp reg=%0d data=%h",
                             n_alu, q_reg[i], q_data[i], 4'(8 + n_alu), 32'hA000 + 32'(n_alu));
        end
        n_alu++;
      end
    end
    checks++; if (n_alu != 4) begin errors++; $display("FAIL bp_alu_count got %0d exp 4", n_alu); end
    checks++; if (busy_mask !== 16'h0 || alu_ready !== 1'b1) begin
      errors++; $display("FAIL bp_drained got busy=%h ready=%b exp 0000/1", busy_mask, alu_ready);
    end
  endtask

  task automatic test_r0_drop();
    do_reset();
    clear_mon();
    mem_valid = 1'b1; mem_reg = 4'd0; mem_data = 32'h12345678;
    @(negedge clk);
    mem_valid = 1'b0;
    checks++; if (busy_mask !== 16'h0) begin errors++; $display("FAIL r0_busy_buf got %h exp 0000", busy_mask); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_we got %b exp 0", rf_we); end
    checks++; if (write_data !== 32'h12345678 || grant_mem !== 1'b1 || write_reg !== 4'd0) begin
      errors++; $display("FAIL r0_popped got reg=%0d data=%h gm=%b exp 0/12345678/1", write_reg, write_data, grant_mem);
    end
    @(negedge clk);
    checks++; if (rf_we !== 1'b0 || busy_mask !== 16'h0 || q_reg.size() != 0) begin
      errors++; $display("FAIL r0_after got we=%b busy=%h writes=%0d exp 0/0000/0", rf_we, busy_mask, q_reg.size());
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    push_pairs();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL midrst_pre_we got %b exp 1", rf_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0 || busy_mask !== 16'h0) begin
      errors++; $display("FAIL midrst_async got we=%b busy=%h exp 0/0000", rf_we, busy_mask);
    end
    repeat (2) @(negedge clk);
    clear_mon();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (q_reg.size() != 0 || busy_mask !== 16'h0) begin
      errors++; $display("FAIL midrst_stale got writes=%0d busy=%h exp 0/0000", q_reg.size(), busy_mask);
    end
    alu_valid = 1'b1; alu_reg = 4'd9;  alu_data = 32'h99;
    mem_valid = 1'b1; mem_reg = 4'd10; mem_data = 32'hAA;
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
`ifdef RF_WB_FIXED_PRI_EN
    checks++; if (rf_we !== 1'b1 || write_reg !== 4'd10 || grant_mem !== 1'b1) begin
      errors++; $display("FAIL midrst_first_grant got we=%b reg=%0d gm=%b exp 1/10/1", rf_we, write_reg, grant_mem);
    end
`else
    checks++; if (rf_we !== 1'b1 || write_reg !== 4'd9 || grant_mem !== 1'b0) begin
      errors++; $display("FAIL midrst_first_grant got we=%b reg=%0d gm=%b exp 1/9/0", rf_we, write_reg, grant_mem);
    end
`endif
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_backpressure();
    test_r0_drop();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
